// File: rtl/accel_tilt_filter.sv
// accel_tilt_filter: 8-sample moving average of raw accelerometer Y samples,
// quantised to a debounced 4-bit steering code plus a 32-bit register word.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_sample_valid i_sample_data carries a new sample this cycle
//   i_sample_data  signed 12-bit Y-axis sample
//   o_tilt_code    debounced code: 0 full left, 8 centre, 15 full right
//   o_avg_out      signed moving average behind the last candidate
//   o_accel_word   {16'h0, o_avg_out, o_tilt_code}
//   o_code_valid   pulse: a candidate was evaluated
//   o_code_changed pulse with o_code_valid when o_tilt_code changed
module accel_tilt_filter #(
    parameter int AVG_LOG2 = 3,
    parameter int DEADZONE = 64,
    parameter int HOLD     = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_sample_valid,
    input  logic [11:0] i_sample_data,
    output logic [3:0]  o_tilt_code,
    output logic [11:0] o_avg_out,
    output logic [31:0] o_accel_word,
    output logic        o_code_valid,
    output logic        o_code_changed
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 12 + AVG_LOG2;
    localparam int RW    = $clog2(HOLD + 1);

    localparam logic signed [11:0] DZ_P = 12'(DEADZONE);
    localparam logic signed [11:0] DZ_N = 12'(-DEADZONE);

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [11:0]          r_buf [DEPTH];
    logic [AVG_LOG2-1:0]  r_wptr;
    logic [AVG_LOG2-1:0]  r_fill;
    logic signed [SW-1:0] r_sum;
    logic signed [SW-1:0] w_sum_nxt;
    logic signed [SW-1:0] w_new;
    logic signed [SW-1:0] w_old;
    logic                 w_eval;
    logic                 r_eval;

    logic signed [11:0]   w_avg;
    logic                 w_dead;
    logic [3:0]           w_cand;
    logic [RW-1:0]        w_run_nxt;
    logic                 w_change;

    logic [3:0]           r_last;
    logic [RW-1:0]        r_run;
    logic [3:0]           r_tilt;
    logic [11:0]          r_avg;
    logic                 r_valid;
    logic                 r_changed;

    // ---------------- stage 1: window and running sum ----------------

    assign w_new = {{AVG_LOG2{i_sample_data[11]}}, i_sample_data};
    assign w_old = {{AVG_LOG2{r_buf[r_wptr][11]}}, r_buf[r_wptr]};

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_eval      = 1'b0;
        if (i_sample_valid) begin
            unique case (r_state)
                S_FILL: begin
                    // Oldest slot is stale during fill; never subtract it.
                    w_sum_nxt = r_sum + w_new;
                    if (r_fill == AVG_LOG2'(DEPTH - 1)) begin
                        w_state_nxt = S_RUN;
                        w_eval      = 1'b1;
                    end
                end
                S_RUN: begin
                    w_sum_nxt = r_sum + w_new - w_old;
                    w_eval    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_FILL;
            r_wptr  <= '0;
            r_fill  <= '0;
            r_sum   <= '0;
            r_eval  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            r_eval  <= w_eval;
            if (i_sample_valid) begin
                r_wptr <= r_wptr + 1'b1;
                if (r_state == S_FILL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge i_clock) begin
        if (i_sample_valid) begin
            r_buf[r_wptr] <= i_sample_data;
        end
    end

    // ---------------- stage 2: quantise and debounce ----------------

    // Arithmetic shift of the sum; the result always fits in 12 bits.
    assign w_avg  = r_sum[SW-1:AVG_LOG2];
    assign w_dead = (w_avg < DZ_P) && (w_avg > DZ_N);

    // (avg >>> 8) + 8 in 4 bits is avg[11:8] with the sign bit flipped.
    assign w_cand = w_dead ? 4'd8 : {~w_avg[11], w_avg[10:8]};

    always_comb begin
        w_run_nxt = r_run;
        if (w_cand != r_last) begin
            w_run_nxt = RW'(1);
        end else if (r_run != RW'(HOLD)) begin
            w_run_nxt = r_run + 1'b1;
        end
    end

    assign w_change = (w_run_nxt == RW'(HOLD)) && (w_cand != r_tilt);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last    <= 4'd8;
            r_run     <= '0;
            r_tilt    <= 4'd8;
            r_avg     <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_valid   <= r_eval;
            r_changed <= r_eval && w_change;
            if (r_eval) begin
                r_avg  <= w_avg;
                r_last <= w_cand;
                r_run  <= w_run_nxt;
                if (w_change) begin
                    r_tilt <= w_cand;
                end
            end
        end
    end

    assign o_tilt_code    = r_tilt;
    assign o_avg_out      = r_avg;
    assign o_accel_word   = {16'h0, r_avg, r_tilt};
    assign o_code_valid   = r_valid;
    assign o_code_changed = r_changed;

endmodule
